// File: rtl/clock_monitor.sv
// Fast-domain monitor for a divided clock: synchronizes mon_in, emits edge pulses,
// measures half-periods in in_clk cycles, tracks lock and raises a sticky error.
module clock_monitor #(
  parameter int unsigned EXP_HALF = 501,
  parameter int unsigned TOL      = 4,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned CW       = 11
) (
  input  logic          in_clk,
  input  logic          rst,
  input  logic          mon_in,
  input  logic          clr,
  output logic          rise_pulse,
  output logic          fall_pulse,
  output logic [CW-1:0] half_period,
  output logic          half_valid,
  output logic          locked,
  output logic          err
);

  localparam int unsigned SW = $clog2(LOCK_CNT + 1);
  localparam logic [CW:0]   M_LO       = (CW+1)'(EXP_HALF - TOL);
  localparam logic [CW:0]   M_HI       = (CW+1)'(EXP_HALF + TOL);
  localparam logic [CW-1:0] TMO_PRE    = CW'(2 * (EXP_HALF + TOL) - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(LOCK_CNT);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

  state_t        state, state_d;
  logic          s1, s2, s3;
  logic          edge_rise, edge_fall, edge_any;
  logic [CW-1:0] cnt;
  logic [CW:0]   m_wide;
  logic [CW-1:0] m;
  logic          in_tol, timeout;
  logic [SW-1:0] streak, streak_d;
  logic          meas_d, err_set;

  assign edge_rise = s2 & ~s3;
  assign edge_fall = ~s2 & s3;
  assign edge_any  = edge_rise | edge_fall;

  assign m_wide = {1'b0, cnt} + (CW+1)'(1);
  assign m      = m_wide[CW] ? '1 : m_wide[CW-1:0];
  assign in_tol = (m_wide >= M_LO) && (m_wide <= M_HI);

  // Detected one cycle early so the registered state change lands in the
  // same cycle cnt reads T; cnt passes T-1 only once, so it cannot repeat.
  assign timeout = ~edge_any && (cnt == TMO_PRE);

  always_comb begin
    state_d  = state;
    streak_d = streak;
    meas_d   = 1'b0;
    err_set  = 1'b0;
    unique case (state)
      UNLOCKED: begin
        if (edge_any) begin
          state_d  = ACQUIRE;
          streak_d = '0;
        end
      end
      ACQUIRE: begin
        if (edge_any) begin
          meas_d = 1'b1;
          if (in_tol) begin
            streak_d = streak + SW'(1);
            if (streak_d == STREAK_MAX) state_d = LOCKED;
          end else begin
            streak_d = '0;
          end
        end else if (timeout) begin
          state_d  = UNLOCKED;
          streak_d = '0;
        end
      end
      LOCKED: begin
        if (edge_any) begin
          meas_d = 1'b1;
          if (!in_tol) begin
            state_d  = ACQUIRE;
            streak_d = '0;
            err_set  = 1'b1;
          end
        end else if (timeout) begin
          state_d  = UNLOCKED;
          streak_d = '0;
          err_set  = 1'b1;
        end
      end
      default: begin
        state_d  = UNLOCKED;
        streak_d = '0;
      end
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (rst) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
      cnt         <= '0;
      state       <= UNLOCKED;
      streak      <= '0;
      half_valid  <= 1'b0;
      half_period <= '0;
      locked      <= 1'b0;
      err         <= 1'b0;
    end else begin
      s1         <= mon_in;
      s2         <= s1;
      s3         <= s2;
      rise_pulse <= edge_rise;
      fall_pulse <= edge_fall;
      if (edge_any)      cnt <= '0;
      else if (cnt != '1) cnt <= cnt + CW'(1);
      state      <= state_d;
      streak     <= streak_d;
      half_valid <= meas_d;
      if (meas_d) half_period <= m;
      locked     <= (state_d == LOCKED);
      // A new error outranks a simultaneous clear.
      if (err_set)  err <= 1'b1;
      else if (clr) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor: lock, tolerance edges, drift, stall, clr, mid-run reset.
module tb_clock_monitor;

  logic        in_clk = 1'b0;
  logic        rst    = 1'b1;
  logic        mon_in = 1'b0;
  logic        clr    = 1'b0;
  logic        rise_pulse, fall_pulse, half_valid, locked, err;
  logic [10:0] half_period;

  clock_monitor #(
    .EXP_HALF (501),
    .TOL      (4),
    .LOCK_CNT (4),
    .CW       (11)
  ) dut (
    .in_clk      (in_clk),
    .rst         (rst),
    .mon_in      (mon_in),
    .clr         (clr),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .half_period (half_period),
    .half_valid  (half_valid),
    .locked      (locked),
    .err         (err)
  );

  always #5 in_clk = ~in_clk;

  int unsigned cyc = 0;
  always @(posedge in_clk) cyc <= cyc + 1;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  // Monitor: logs every half_valid with the locked/err seen in the same cycle.
  int unsigned hv_q[$];
  bit          lk_q[$];
  bit          er_q[$];
  int unsigned n_rise = 0, n_fall = 0, last_pulse_cyc = 0, unlock_cyc = 0;
  logic        lk_prev = 1'b0;

  always @(negedge in_clk) begin
    if (half_valid) begin
      hv_q.push_back(int'(half_period));
      lk_q.push_back(locked);
      er_q.push_back(err);
    end
    if (rise_pulse) n_rise++;
    if (fall_pulse) n_fall++;
    if (rise_pulse || fall_pulse) last_pulse_cyc = cyc;
    if (lk_prev && !locked) unlock_cyc = cyc;
    lk_prev = locked;
  end

  int unsigned b_hv = 0, b_rise = 0, b_fall = 0, tgl_cyc = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge in_clk);
      #1;
    end
  endtask

  // Toggle mon_in exactly n in_clk cycles after the previous toggle.
  task automatic gap(input int unsigned n);
    do tick(1); while (cyc < tgl_cyc + n);
    mon_in  = ~mon_in;
    tgl_cyc = cyc;
  endtask

  task automatic mark();
    b_hv   = hv_q.size();
    b_rise = n_rise;
    b_fall = n_fall;
  endtask

  task automatic do_reset();
    tick(1);
    rst    = 1'b1;
    mon_in = 1'b0;
    clr    = 1'b0;
    tick(2);
    rst     = 1'b0;
    tgl_cyc = cyc;
    mark();
  endtask

  task automatic check_meas(input string tag, input int unsigned n, input int unsigned val,
                            input int unsigned lock_at, input bit err_exp);
    int unsigned got_n;
    got_n = hv_q.size() - b_hv;
    check_val({tag, "_count"}, got_n, n);
    for (int unsigned i = 0; i < n && i < got_n; i++) begin
      check_val($sformatf("%s_hp%0d", tag, i), hv_q[b_hv+i], val);
      check_val($sformatf("%s_lk%0d", tag, i), 32'(lk_q[b_hv+i]), 32'(i >= lock_at));
      check_val($sformatf("%s_er%0d", tag, i), 32'(er_q[b_hv+i]), 32'(err_exp));
    end
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_rise"}, 32'(rise_pulse), 0);
    check_val({tag, "_fall"}, 32'(fall_pulse), 0);
    check_val({tag, "_hv"},   32'(half_valid), 0);
    check_val({tag, "_hp"},   32'(half_period), 0);
    check_val({tag, "_lk"},   32'(locked), 0);
    check_val({tag, "_err"},  32'(err), 0);
  endtask

  task automatic lock_501();
    gap(10);
    repeat (4) gap(501);
    tick(5);
  endtask

  int unsigned bnd_val[4] = '{497, 505, 496, 506};
  int unsigned bnd_lk[4]  = '{3, 3, 99, 99};

  initial begin
    // Reset state and lock acquisition, including edge-pulse latency.
    do_reset();
    check_idle("reset");
    gap(10);
    repeat (3) @(negedge in_clk);
    check_val("lat_k2", 32'(rise_pulse), 0);
    @(negedge in_clk);
    check_val("lat_k3", 32'(rise_pulse), 1);
    check_val("first_hv", 32'(half_valid), 0);
    @(negedge in_clk);
    check_val("lat_k4", 32'(rise_pulse), 0);
    repeat (4) gap(501);
    tick(5);
    check_meas("lock", 4, 501, 3, 0);
    check_val("lock_rises", n_rise - b_rise, 3);
    check_val("lock_falls", n_fall - b_fall, 2);
    check_val("lock_now", 32'(locked), 1);

    // Tolerance boundaries.
    for (int k = 0; k < 4; k++) begin
      do_reset();
      gap(10);
      repeat (5) gap(bnd_val[k]);
      tick(5);
      check_meas($sformatf("bnd%0d", bnd_val[k]), 5, bnd_val[k], bnd_lk[k], 0);
    end

    // Drift while locked, then relock with err held.
    do_reset();
    lock_501();
    mark();
    gap(510);
    tick(4);
    check_meas("drift", 1, 510, 99, 1);
    mark();
    repeat (4) gap(501);
    tick(5);
    check_meas("relock", 4, 501, 3, 1);

    // Stall: timeout exactly T cycles after the last edge pulse.
    do_reset();
    lock_501();
    check_val("stall_pre_lk", 32'(locked), 1);
    tick(1100);
    check_val("stall_delay", unlock_cyc - last_pulse_cyc, 1010);
    check_val("stall_lk", 32'(locked), 0);
    check_val("stall_err", 32'(err), 1);
    mark();
    gap(1200);
    tick(5);
    check_val("stall_discard", hv_q.size() - b_hv, 0);
    check_val("stall_edge", (n_rise - b_rise) + (n_fall - b_fall), 1);

    // clr alone clears; clr with a fresh error keeps err set.
    check_val("clr_pre", 32'(err), 1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check_val("clr_alone", 32'(err), 0);
    repeat (4) gap(501);
    tick(5);
    check_val("clr_relock", 32'(locked), 1);
    check_val("clr_relock_err", 32'(err), 0);
    gap(510);
    tick(2);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check_val("clr_vs_set_err", 32'(err), 1);
    check_val("clr_vs_set_lk", 32'(locked), 0);
    check_val("clr_vs_set_hp", 32'(half_period), 510);

    // One-cycle reset while locked with mon_in high.
    do_reset();
    lock_501();
    check_val("mid_pre_lk", 32'(locked), 1);
    rst = 1'b1;
    tick(1);
    rst     = 1'b0;
    tgl_cyc = cyc;
    mark();
    check_idle("mid_rst");
    repeat (4) gap(501);
    tick(5);
    check_meas("mid_relock", 4, 501, 3, 0);
    check_val("mid_rises", n_rise - b_rise, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
